// File: rtl/cnt_min_hour.sv
// rtl/cnt_min_hour.sv - BCD minute/hour time-of-day counter with set-time FSM
// Counts seconds carries into minutes/hours and lets two buttons set the time.
module cnt_min_hour (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       sec_carry,
  input  logic       set_btn,
  input  logic       inc_btn,
  output logic [3:0] min_L,
  output logic [3:0] min_H,
  output logic [3:0] hour_L,
  output logic [3:0] hour_H,
  output logic       set_hour,
  output logic       set_min,
  output logic       sec_clr,
  output logic       chime,
  output logic       day_carry
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] min_nxt, hour_nxt;
  logic       sec_clr_nxt, chime_nxt, day_carry_nxt;
  logic       min_wrap, hour_wrap;

  // Digit pairs are {tens, units}; only valid BCD is ever reachable.
  function automatic logic [7:0] inc_min(input logic [7:0] m);
    if (m == 8'h59)
      inc_min = 8'h00;
    else if (m[3:0] == 4'd9)
      inc_min = {m[7:4] + 4'd1, 4'd0};
    else
      inc_min = {m[7:4], m[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] h);
    if (h == 8'h23)
      inc_hour = 8'h00;
    else if (h[3:0] == 4'd9)
      inc_hour = {h[7:4] + 4'd1, 4'd0};
    else
      inc_hour = {h[7:4], h[3:0] + 4'd1};
  endfunction

  assign min_wrap  = ({min_H, min_L} == 8'h59);
  assign hour_wrap = ({hour_H, hour_L} == 8'h23);

  always_comb begin
    state_nxt     = state;
    min_nxt       = {min_H, min_L};
    hour_nxt      = {hour_H, hour_L};
    sec_clr_nxt   = 1'b0;
    chime_nxt     = 1'b0;
    day_carry_nxt = 1'b0;
    case (state)
      RUN: begin
        // A carry arriving with set_btn still lands before entering SET_HOUR.
        if (sec_carry) begin
          min_nxt = inc_min({min_H, min_L});
          if (min_wrap) begin
            hour_nxt      = inc_hour({hour_H, hour_L});
            chime_nxt     = 1'b1;
            day_carry_nxt = hour_wrap;
          end
        end
        if (set_btn)
          state_nxt = SET_HOUR;
      end
      SET_HOUR: begin
        if (set_btn)
          state_nxt = SET_MIN;
        else if (inc_btn)
          hour_nxt = inc_hour({hour_H, hour_L});
      end
      SET_MIN: begin
        if (set_btn) begin
          state_nxt   = RUN;
          sec_clr_nxt = 1'b1;
        end else if (inc_btn) begin
          min_nxt = inc_min({min_H, min_L});
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= RUN;
      min_L     <= 4'd0;
      min_H     <= 4'd0;
      hour_L    <= 4'd0;
      hour_H    <= 4'd0;
      sec_clr   <= 1'b0;
      chime     <= 1'b0;
      day_carry <= 1'b0;
    end else begin
      state            <= state_nxt;
      {min_H, min_L}   <= min_nxt;
      {hour_H, hour_L} <= hour_nxt;
      sec_clr          <= sec_clr_nxt;
      chime            <= chime_nxt;
      day_carry        <= day_carry_nxt;
    end
  end

  assign set_hour = (state == SET_HOUR);
  assign set_min  = (state == SET_MIN);

endmodule

// File: tb/tb_cnt_min_hour.sv
// tb/tb_cnt_min_hour.sv - directed self-checking bench for cnt_min_hour
module tb_cnt_min_hour;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       sec_carry = 1'b0;
  logic       set_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [3:0] min_L, min_H, hour_L, hour_H;
  logic       set_hour, set_min, sec_clr, chime, day_carry;

  int n_checks = 0;
  int n_pass   = 0;

  cnt_min_hour dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .sec_carry (sec_carry),
    .set_btn   (set_btn),
    .inc_btn   (inc_btn),
    .min_L     (min_L),
    .min_H     (min_H),
    .hour_L    (hour_L),
    .hour_H    (hour_H),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .sec_clr   (sec_clr),
    .chime     (chime),
    .day_carry (day_carry)
  );

  always #5 clk = ~clk;

  wire [15:0] t_now = {hour_H, hour_L, min_H, min_L};
  wire [2:0]  pulses = {sec_clr, chime, day_carry};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] bcd(input int v);
    bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  // Inputs change on the falling edge, are captured on the next rising edge,
  // and the result is inspected at the following falling edge.
  task automatic step(input logic sc, input logic sb, input logic ib);
    sec_carry = sc;
    set_btn   = sb;
    inc_btn   = ib;
    @(negedge clk);
    sec_carry = 1'b0;
    set_btn   = 1'b0;
    inc_btn   = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_time", t_now, 16'h0000);
    check("rst_mode", {set_hour, set_min}, 2'b00);
    check("rst_pulses", pulses, 3'b000);
    clr_n = 1'b1;
    @(negedge clk);
    check("post_rst_time", t_now, 16'h0000);

    // 60 carries: 00:00 -> 01:00 with chime only on the last update
    for (int i = 1; i <= 60; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check("run_min", t_now, {bcd(i / 60), bcd(i % 60)});
      check("run_chime", chime, (i == 60));
      check("run_day", day_carry, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    check("chime_1cyc", chime, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("run_inc_ignored", t_now, 16'h0100);

    // preload 23:59 through the set FSM
    step(1'b0, 1'b1, 1'b0);
    check("enter_set_hour", {set_hour, set_min}, 2'b10);
    for (int i = 0; i < 22; i++) step(1'b0, 1'b0, 1'b1);
    check("hour_23", t_now, 16'h2300);
    step(1'b0, 1'b1, 1'b0);
    check("enter_set_min", {set_hour, set_min}, 2'b01);
    for (int i = 0; i < 59; i++) step(1'b0, 1'b0, 1'b1);
    check("preload_2359", t_now, 16'h2359);
    step(1'b0, 1'b1, 1'b0);
    check("exit_sec_clr", sec_clr, 1'b1);
    check("exit_mode", {set_hour, set_min}, 2'b00);
    step(1'b0, 1'b0, 1'b0);
    check("sec_clr_1cyc", sec_clr, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("day_wrap_time", t_now, 16'h0000);
    check("day_wrap_pulses", pulses, 3'b011);
    step(1'b0, 1'b0, 1'b0);
    check("day_wrap_clear", pulses, 3'b000);

    // SET_HOUR: 25 incs with interleaved carries that must be ignored
    step(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 25; i++) begin
      step(1'(i % 2), 1'b0, 1'b1);
      check("sh_hour", t_now, {bcd(i % 24), 8'h00});
      check("sh_flag", set_hour, 1'b1);
      check("sh_pulses", pulses, 3'b000);
    end
    step(1'b1, 1'b0, 1'b0);
    check("sh_carry_frozen", t_now, 16'h0100);

    // SET_MIN: wrap 59 -> 00 with no chime, then set+inc exits
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 59; i++) step(1'b0, 1'b0, 1'b1);
    check("sm_0159", t_now, 16'h0159);
    step(1'b0, 1'b0, 1'b1);
    check("sm_wrap", t_now, 16'h0100);
    check("sm_wrap_pulses", pulses, 3'b000);
    step(1'b0, 1'b1, 1'b1);
    check("set_inc_time", t_now, 16'h0100);
    check("set_inc_mode", {set_hour, set_min}, 2'b00);
    check("set_inc_sec_clr", sec_clr, 1'b1);

    // 12:34 then set+carry in RUN
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 34; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("preload_1234", t_now, 16'h1234);
    step(1'b1, 1'b1, 1'b0);
    check("set_carry_time", t_now, 16'h1235);
    check("set_carry_mode", {set_hour, set_min}, 2'b10);

    // reach 07:42 in SET_MIN, then async reset mid-cycle
    for (int i = 0; i < 19; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1);
    check("preload_0742", t_now, 16'h0742);
    check("preload_0742_mode", {set_hour, set_min}, 2'b01);
    #2 clr_n = 1'b0;
    #1;
    check("async_rst_time", t_now, 16'h0000);
    check("async_rst_mode", {set_hour, set_min}, 2'b00);
    check("async_rst_pulses", pulses, 3'b000);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    check("rst_no_sec_clr", sec_clr, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("after_rst_carry", t_now, 16'h0001);

    // carry with set_btn in SET_MIN is dropped
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("sm_carry_drop", t_now, 16'h0001);
    check("sm_carry_mode", {set_hour, set_min}, 2'b00);
    check("sm_carry_sec_clr", sec_clr, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cnt_min_hour.md
# cnt_min_hour

Minute/hour time-of-day stage of the digital clock. Consumes the one-cycle `carry` pulse from the seconds counter and keeps BCD minutes (00–59) and hours (00–23). Provides a three-state set-time FSM driven by two debounced buttons. Emits a seconds-clear pulse when setting ends, plus hourly-chime and day-rollover pulses for downstream blocks.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single system clock; all logic on posedge.
- `clr_n`  in  1  asynchronous, active-low reset.
- `sec_carry`  in  1  one-cycle pulse from the seconds counter on 59→00 wrap.
- `set_btn`  in  1  debounced, synchronous one-cycle pulse; advances the FSM.
- `inc_btn`  in  1  debounced, synchronous one-cycle pulse; increments the selected field.
- `min_L`  out  4  minutes units, BCD 0–9.
- `min_H`  out  4  minutes tens, BCD 0–5.
- `hour_L`  out  4  hours units, BCD 0–9.
- `hour_H`  out  4  hours tens, BCD 0–2.
- `set_hour`  out  1  high while in SET_HOUR; display blinks the hour digits.
- `set_min`  out  1  high while in SET_MIN; display blinks the minute digits.
- `sec_clr`  out  1  one-cycle active-high pulse that drives the seconds counter's `clr`.
- `chime`  out  1  one-cycle pulse on every hour rollover in RUN.
- `day_carry`  out  1  one-cycle pulse on the 23:59→00:00 wrap.

## Operation
- FSM states: RUN, SET_HOUR, SET_MIN. Reset state is RUN.
- Transitions on `set_btn`: RUN→SET_HOUR→SET_MIN→RUN. No other inputs change state.
- RUN behaviour:
  - `sec_carry` increments minutes.
  - Minutes 59→00 increments hours and pulses `chime`.
  - Time 23:59→00:00 pulses both `chime` and `day_carry`.
  - `inc_btn` is ignored.
- SET_HOUR behaviour:
  - `sec_carry` is ignored; time is frozen.
  - `inc_btn` increments hours mod 24 (23→00). Minutes do not change, and no `chime` or `day_carry` is produced.
- SET_MIN behaviour:
  - `sec_carry` is ignored.
  - `inc_btn` increments minutes mod 60 (59→00). Hours do not change, and no `chime` or `day_carry` is produced.
- Leaving SET_MIN for RUN pulses `sec_clr` so seconds restart at 00.
- Arithmetic rules:
  - Units digit 9→0 carries into the tens digit.
  - Minute wrap is min_H=5 and min_L=9 → 0/0.
  - Hour wrap is hour_H=2 and hour_L=3 → 0/0; 09→10 and 19→20 carry normally.
  - Invalid BCD values are unreachable; no recovery logic is required.
- Simultaneous events:
  - `set_btn` together with `inc_btn`: `set_btn` wins and `inc_btn` is dropped.
  - `set_btn` together with `sec_carry` in RUN: the carry is applied (time increments, including any chime/day_carry) and the state moves to SET_HOUR in the same edge.
  - `sec_carry` together with `set_btn` in SET_MIN: the carry is dropped, the state moves to RUN, and `sec_clr` fires.
- An input held high for N cycles acts as N pulses. Callers must supply single-cycle pulses.

## Timing
- Reset values (while `clr_n`=0 and immediately after release):
  - `min_L`=`min_H`=`hour_L`=`hour_H`=0.
  - State RUN, so `set_hour`=`set_min`=0.
  - `sec_clr`=`chime`=`day_carry`=0.
- Reset is asynchronous assert and synchronous release at the next posedge. Asserting it mid-set returns the FSM to RUN at 00:00 with no `sec_clr` pulse.
- All outputs are registered, with latency 1 cycle: an input sampled at edge k is visible on outputs after edge k.
- `chime`, `day_carry` and `sec_clr` are high for exactly one cycle, coincident with the digit/state update that caused them, and deassert at the next edge.
- `set_hour` and `set_min` are decoded from the state register and change on the same edge as the state.
- Back-to-back `sec_carry` on consecutive cycles must each increment (no dead cycle).

## Test plan
- Reset, then 60 `sec_carry` pulses → minutes step 00…59→00, hours 00→01, `chime` high exactly once, and only on the 60th update.
- Preload 23:59 via the set FSM, return to RUN, 1 `sec_carry` → 00:00, `chime`=1 and `day_carry`=1 for one cycle, `sec_clr` pulsed once on the prior exit from SET_MIN.
- Enter SET_HOUR and apply 25 `inc_btn` → hours 00→…→23→00→01, minutes unchanged; concurrent `sec_carry` pulses have no effect; `set_hour`=1 throughout.
- In SET_MIN at 59, `inc_btn` → 00 with hours unchanged and no `chime`. Then `set_btn` together with `inc_btn` → state RUN, minutes stay 00, `sec_clr`=1 for one cycle.
- In RUN at 12:34, `set_btn` together with `sec_carry` → 12:35 and state SET_HOUR on the same edge.
- Pull `clr_n` low mid-SET_MIN at 07:42 → outputs immediately 00:00, state RUN, all pulses 0; after release, a `sec_carry` gives 00:01.
